// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues word requests to instruction memory, buffers
// returned words with their PCs in an in-order FIFO and handles redirects.
module fetch_prefetch_unit #(
    parameter int              DW              = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [DW-1:0]   RESET_PC        = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    output logic [DW-1:0] instr_o,
    output logic [DW-1:0] pc_o,
    output logic [DW-1:0] pc_plus_4_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [DW-1:0] instr_mem [DEPTH];
    logic [DW-1:0] pc_mem    [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [OW-1:0] outstanding_reg;
    logic [OW-1:0] discard_reg;
    logic [DW-1:0] fetch_pc_reg;
    logic [DW-1:0] ret_pc_reg;

    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic [15:0]   in_use;
    logic [OW-1:0] outstanding_next;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Entries still owed to the FIFO: buffered words plus live (non-discarded) requests.
    assign in_use     = 16'(count_reg) + 16'(outstanding_reg) - 16'(discard_reg);
    assign imem_req_o = rst_i && !redirect_i
                        && (outstanding_reg < OW'(MAX_OUTSTANDING))
                        && (in_use < 16'(DEPTH));
    assign imem_addr_o = fetch_pc_reg;

    assign grant = imem_req_o && imem_gnt_i;
    // Responses with nothing outstanding belong to requests cut off by reset.
    assign resp  = imem_rvalid_i && (outstanding_reg != '0);
    assign push  = resp && (discard_reg == '0);
    assign pop   = instr_valid_o && instr_ready_i;
    assign wr_en = push && !redirect_i;

    assign outstanding_next = outstanding_reg + OW'(grant) - OW'(resp);

    assign instr_valid_o = (count_reg != '0);
    assign instr_o       = instr_valid_o ? instr_mem[rd_ptr_reg] : '0;
    assign pc_o          = instr_valid_o ? pc_mem[rd_ptr_reg] : '0;
    assign pc_plus_4_o   = instr_valid_o ? pc_mem[rd_ptr_reg] + DW'(4) : '0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (wr_en && (wr_ptr_reg == PW'(gi))) begin
                    instr_mem[gi] <= imem_rdata_i;
                    pc_mem[gi]    <= ret_pc_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_pc_reg    <= RESET_PC;
            ret_pc_reg      <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (redirect_i) begin
                // Everything still in flight after this cycle is stale.
                fetch_pc_reg <= {redirect_pc_i[DW-1:2], 2'b00};
                ret_pc_reg   <= {redirect_pc_i[DW-1:2], 2'b00};
                discard_reg  <= outstanding_next;
                count_reg    <= '0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
            end else begin
                if (grant) begin
                    fetch_pc_reg <= fetch_pc_reg + DW'(4);
                end
                if (resp && (discard_reg != '0)) begin
                    discard_reg <= discard_reg - OW'(1);
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    ret_pc_reg <= ret_pc_reg + DW'(4);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(wr_en && (count_reg == CW'(DEPTH))));

endmodule
